// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: state encoding, credit width
// and the product price table.
package vend_pkg;

  localparam int CREDIT_W = 5;

  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_CREDIT   = 3'b001;
  localparam logic [2:0] ST_DISPENSE = 3'b010;
  localparam logic [2:0] ST_CHANGE   = 3'b011;

  // Price in credit units for each of the four products.
  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] code);
    logic [CREDIT_W-1:0] p;
    case (code)
      2'd0:    p = 5'd5;
      2'd1:    p = 5'd8;
      2'd2:    p = 5'd10;
      default: p = 5'd12;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Restartable cycle counter shared by the inactivity and dispense timeouts.
// i_load restarts counting from zero, i_clear disarms, o_expire is high on
// the LIMIT-th cycle after the load so the owner acts on that edge.
module vend_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expire
);

  localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_armed;
  logic             w_at_limit;

  assign w_at_limit = (r_count == CNT_W'(LIMIT - 1));
  assign o_expire   = r_armed && w_at_limit;

  // Count while armed; hold at the limit until the owner reloads or clears.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (i_load) begin
      r_count <= '0;
      r_armed <= 1'b1;
    end else if (r_armed && !w_at_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: accumulates coin credit, dispenses a selected
// product, and pays change one coin at a time. All outputs are registered.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int CREDIT_MAX = 20,
  parameter int TIMEOUT    = 255,
  parameter int CHG_COIN   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_valid,
  input  logic [3:0] coin_value,
  input  logic       sel_valid,
  input  logic [1:0] sel_code,
  input  logic       cancel,
  output logic       disp_req,
  output logic [1:0] disp_item,
  input  logic       disp_ack,
  output logic       chg_req,
  output logic [3:0] chg_amt,
  input  logic       chg_ack,
  output logic [4:0] credit,
  output logic [2:0] states,
  output logic       coin_reject,
  output logic       short_credit,
  output logic       fault
);

  logic [2:0]          r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_disp_req;
  logic [1:0]          r_disp_item;
  logic                r_chg_req;
  logic [3:0]          r_chg_amt;
  logic                r_coin_reject;
  logic                r_short_credit;
  logic                r_fault;

  logic [2:0]          w_state_next;
  logic [CREDIT_W-1:0] w_credit_next;
  logic [1:0]          w_item_next;
  logic                w_fault_next;
  logic                w_short_next;
  logic                w_tmr_load;
  logic                w_tmr_clear;
  logic                w_expire;
  logic [3:0]          w_chg_amt_next;

  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_state;
  logic                w_coin_ok;
  logic                w_coin_rej;
  logic [CREDIT_W-1:0] w_coin_add;
  logic [CREDIT_W-1:0] w_price;
  logic [CREDIT_W-1:0] w_item_price;
  logic [CREDIT_W-1:0] w_change_left;

  // Coin qualification: only IDLE/CREDIT take coins, never past the credit cap
  // and never in the cycle the customer cancels. Zero-value coins are no-ops.
  assign w_sum         = {1'b0, r_credit} + {2'b00, coin_value};
  assign w_coin_state  = (r_state == ST_IDLE) || (r_state == ST_CREDIT);
  assign w_coin_ok     = coin_valid && (coin_value != 4'd0) && !cancel && w_coin_state
                         && (w_sum <= (CREDIT_W+1)'(CREDIT_MAX));
  assign w_coin_rej    = coin_valid && (coin_value != 4'd0) && !w_coin_ok;
  assign w_coin_add    = w_coin_ok ? {1'b0, coin_value} : '0;
  assign w_price       = price_of(sel_code);
  assign w_item_price  = price_of(r_disp_item);
  assign w_change_left = r_credit - {1'b0, r_chg_amt};

  vend_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_tmr_load),
    .i_clear  (w_tmr_clear),
    .o_expire (w_expire)
  );

  // Next-state and next-credit decision for the transaction FSM.
  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_item_next   = r_disp_item;
    w_fault_next  = r_fault;
    w_short_next  = 1'b0;
    w_tmr_load    = 1'b0;
    w_tmr_clear   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_coin_ok) begin
          w_credit_next = w_sum[CREDIT_W-1:0];
          w_state_next  = ST_CREDIT;
          w_tmr_load    = 1'b1;
        end
      end
      ST_CREDIT: begin
        // A timeout behaves like cancel unless a coin lands on that same edge.
        if (cancel || (w_expire && !w_coin_ok)) begin
          w_state_next = ST_CHANGE;
          w_tmr_clear  = 1'b1;
        end else if (sel_valid) begin
          // Price is checked against the credit held before this cycle's coin.
          if (r_credit >= w_price) begin
            w_credit_next = r_credit - w_price + w_coin_add;
            w_item_next   = sel_code;
            w_state_next  = ST_DISPENSE;
            w_tmr_load    = 1'b1;
          end else begin
            w_short_next = 1'b1;
            if (w_coin_ok) begin
              w_credit_next = w_sum[CREDIT_W-1:0];
              w_tmr_load    = 1'b1;
            end
          end
        end else if (w_coin_ok) begin
          w_credit_next = w_sum[CREDIT_W-1:0];
          w_tmr_load    = 1'b1;
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          w_tmr_clear  = 1'b1;
          w_state_next = (r_credit == '0) ? ST_IDLE : ST_CHANGE;
        end else if (w_expire) begin
          // Mechanism never answered: give the price back and flag it.
          w_tmr_clear   = 1'b1;
          w_credit_next = r_credit + w_item_price;
          w_fault_next  = 1'b1;
          w_state_next  = ST_CHANGE;
        end
      end
      ST_CHANGE: begin
        if (r_credit == '0) begin
          w_state_next = ST_IDLE;
        end else if (chg_ack) begin
          w_credit_next = w_change_left;
          if (w_change_left == '0) begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_credit_next = '0;
        w_tmr_clear   = 1'b1;
      end
    endcase
  end

  // Change coin for the upcoming cycle: the largest coin not exceeding credit.
  always_comb begin
    w_chg_amt_next = 4'd0;
    if (w_state_next == ST_CHANGE) begin
      if (w_credit_next > CREDIT_W'(CHG_COIN)) begin
        w_chg_amt_next = 4'(CHG_COIN);
      end else begin
        w_chg_amt_next = w_credit_next[3:0];
      end
    end
  end

  // Register every output; reset abandons any transaction without refund.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_disp_req     <= 1'b0;
      r_disp_item    <= 2'd0;
      r_chg_req      <= 1'b0;
      r_chg_amt      <= 4'd0;
      r_coin_reject  <= 1'b0;
      r_short_credit <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_credit       <= w_credit_next;
      r_disp_req     <= (w_state_next == ST_DISPENSE);
      r_disp_item    <= w_item_next;
      r_chg_req      <= (w_state_next == ST_CHANGE);
      r_chg_amt      <= w_chg_amt_next;
      r_coin_reject  <= w_coin_rej;
      r_short_credit <= w_short_next;
      r_fault        <= w_fault_next;
    end
  end

  assign states       = r_state;
  assign credit       = r_credit;
  assign disp_req     = r_disp_req;
  assign disp_item    = r_disp_item;
  assign chg_req      = r_chg_req;
  assign chg_amt      = r_chg_amt;
  assign coin_reject  = r_coin_reject;
  assign short_credit = r_short_credit;
  assign fault        = r_fault;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with TIMEOUT=16.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_value = 4'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_code = 2'd0;
  logic       cancel = 1'b0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack = 1'b0;
  logic       chg_req;
  logic [3:0] chg_amt;
  logic       chg_ack = 1'b0;
  logic [4:0] credit;
  logic [2:0] states;
  logic       coin_reject;
  logic       short_credit;
  logic       fault;

  int tests = 0;
  int fails = 0;

  vend_sequencer #(.CREDIT_MAX(20), .TIMEOUT(16), .CHG_COIN(5)) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_code(sel_code), .cancel(cancel),
    .disp_req(disp_req), .disp_item(disp_item), .disp_ack(disp_ack),
    .chg_req(chg_req), .chg_amt(chg_amt), .chg_ack(chg_ack),
    .credit(credit), .states(states),
    .coin_reject(coin_reject), .short_credit(short_credit), .fault(fault)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic coin(input logic [3:0] v);
    coin_valid = 1'b1; coin_value = v;
    tick();
    coin_valid = 1'b0; coin_value = 4'd0;
    $display("[TB] coin %0d -> state %0d credit %0d reject %0d", v, states, credit, coin_reject);
  endtask

  task automatic sel(input logic [1:0] c);
    sel_valid = 1'b1; sel_code = c;
    tick();
    sel_valid = 1'b0; sel_code = 2'd0;
    $display("[TB] select %0d -> state %0d credit %0d short %0d", c, states, credit, short_credit);
  endtask

  task automatic dack();
    disp_ack = 1'b1;
    tick();
    disp_ack = 1'b0;
    $display("[TB] disp_ack -> state %0d credit %0d", states, credit);
  endtask

  task automatic cack();
    chg_ack = 1'b1;
    tick();
    chg_ack = 1'b0;
    $display("[TB] chg_ack -> state %0d credit %0d chg_amt %0d", states, credit, chg_amt);
  endtask

  initial begin
    // Reset state
    reset = 1'b1; tick(); reset = 1'b0;
    $display("[TB] reset -> state %0d credit %0d", states, credit);
    chk("rst_state", states, 0);
    chk("rst_credit", credit, 0);
    chk("rst_disp_req", disp_req, 0);
    chk("rst_disp_item", disp_item, 0);
    chk("rst_chg_req", chg_req, 0);
    chk("rst_chg_amt", chg_amt, 0);
    chk("rst_reject", coin_reject, 0);
    chk("rst_short", short_credit, 0);
    chk("rst_fault", fault, 0);

    // Zero-value coin is ignored silently
    coin(4'd0);
    chk("zero_state", states, 0);
    chk("zero_reject", coin_reject, 0);

    // Coins 10+5, buy item 1 (price 8), change 5 then 2
    coin(4'd10);
    chk("c10_state", states, 1);
    chk("c10_credit", credit, 10);
    coin(4'd5);
    chk("c5_credit", credit, 15);
    sel(2'd1);
    chk("s1_state", states, 2);
    chk("s1_disp_req", disp_req, 1);
    chk("s1_item", disp_item, 1);
    chk("s1_credit", credit, 7);
    tick(); tick();
    chk("s1_hold_req", disp_req, 1);
    chk("s1_hold_item", disp_item, 1);
    dack();
    chk("ack_state", states, 3);
    chk("ack_disp_req", disp_req, 0);
    chk("ack_chg_req", chg_req, 1);
    chk("ack_chg_amt", chg_amt, 5);
    cack();
    chk("chg1_credit", credit, 2);
    chk("chg1_amt", chg_amt, 2);
    chk("chg1_state", states, 3);
    cack();
    chk("chg2_credit", credit, 0);
    chk("chg2_state", states, 0);
    chk("chg2_req", chg_req, 0);
    chk("chg2_amt", chg_amt, 0);
    // Stray acknowledges in IDLE
    dack();
    chk("stray_dack_state", states, 0);
    cack();
    chk("stray_cack_credit", credit, 0);

    // Overflow reject at 18, exact-cap accept at 20, buy item 3 -> change 8
    coin(4'd10);
    coin(4'd8);
    chk("c18_credit", credit, 18);
    coin(4'd5);
    chk("ovf_reject", coin_reject, 1);
    chk("ovf_credit", credit, 18);
    coin(4'd2);
    chk("cap_reject", coin_reject, 0);
    chk("cap_credit", credit, 20);
    sel(2'd3);
    chk("s3_state", states, 2);
    chk("s3_credit", credit, 8);
    coin(4'd5);
    chk("disp_coin_reject", coin_reject, 1);
    chk("disp_coin_credit", credit, 8);
    dack();
    chk("s3_chg_amt", chg_amt, 5);
    cack();
    chk("s3_chg_amt2", chg_amt, 3);
    cack();
    chk("s3_done", states, 0);

    // Short credit at 10 for item 3, then same-cycle coin+select cases
    coin(4'd10);
    sel(2'd3);
    chk("short_pulse", short_credit, 1);
    chk("short_state", states, 1);
    chk("short_credit", credit, 10);
    coin_valid = 1'b1; coin_value = 4'd2;
    sel(2'd3);
    coin_valid = 1'b0; coin_value = 4'd0;
    chk("precoin_short", short_credit, 1);
    chk("precoin_credit", credit, 12);
    coin_valid = 1'b1; coin_value = 4'd5;
    sel(2'd3);
    coin_valid = 1'b0; coin_value = 4'd0;
    chk("mix_state", states, 2);
    chk("mix_credit", credit, 5);
    chk("mix_item", disp_item, 3);
    chk("mix_short", short_credit, 0);
    dack();
    chk("mix_chg_amt", chg_amt, 5);
    cack();
    chk("mix_done", states, 0);

    // Cancel beats selection at credit 12: change 5,5,2
    coin(4'd12);
    cancel = 1'b1;
    sel(2'd0);
    cancel = 1'b0;
    chk("cxl_state", states, 3);
    chk("cxl_credit", credit, 12);
    chk("cxl_disp_req", disp_req, 0);
    chk("cxl_amt", chg_amt, 5);
    cack();
    chk("cxl_amt2", chg_amt, 5);
    chk("cxl_credit2", credit, 7);
    cack();
    chk("cxl_amt3", chg_amt, 2);
    cack();
    chk("cxl_done", states, 0);
    chk("cxl_credit_end", credit, 0);

    // Dispense timeout: item 2 at credit 10, no ack for 16 cycles
    coin(4'd10);
    sel(2'd2);
    chk("dto_credit0", credit, 0);
    for (int i = 0; i < 15; i++) tick();
    chk("dto_before_state", states, 2);
    chk("dto_before_req", disp_req, 1);
    tick();
    $display("[TB] dispense timeout -> state %0d credit %0d fault %0d", states, credit, fault);
    chk("dto_state", states, 3);
    chk("dto_req", disp_req, 0);
    chk("dto_fault", fault, 1);
    chk("dto_credit", credit, 10);
    chk("dto_amt", chg_amt, 5);
    cack();
    chk("dto_amt2", chg_amt, 5);
    cack();
    chk("dto_done", states, 0);
    chk("dto_fault_sticky", fault, 1);

    // Inactivity timeout: coin 5 then 16 idle cycles
    coin(4'd5);
    for (int i = 0; i < 15; i++) tick();
    chk("ito_before", states, 1);
    tick();
    $display("[TB] inactivity timeout -> state %0d credit %0d", states, credit);
    chk("ito_state", states, 3);
    chk("ito_credit", credit, 5);
    chk("ito_amt", chg_amt, 5);
    cack();
    chk("ito_done", states, 0);

    // Reset during CHANGE with credit 7, together with a coin
    coin(4'd7);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("pre_rst_state", states, 3);
    chk("pre_rst_credit", credit, 7);
    reset = 1'b1; coin_valid = 1'b1; coin_value = 4'd3;
    tick();
    reset = 1'b0; coin_valid = 1'b0; coin_value = 4'd0;
    $display("[TB] reset mid-change -> state %0d credit %0d", states, credit);
    chk("mid_rst_state", states, 0);
    chk("mid_rst_credit", credit, 0);
    chk("mid_rst_chg_req", chg_req, 0);
    chk("mid_rst_fault", fault, 0);
    chk("mid_rst_reject", coin_reject, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
